// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS/DLX pipeline: datapath widths, load encodings
// and writeback-control bit positions.
package mips_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned HALF_W     = 16;

    // Load sub-type carried down the pipe with each memory instruction
    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LH  = 3'd1,
        LT_LHU = 3'd2,
        LT_LB  = 3'd3,
        LT_LBU = 3'd4
    } load_type_e;

    // Bit positions inside the 2-bit WB control bundle
    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;

endpackage

// File: rtl/load_align.sv
// Big-endian sub-word extraction and alignment check for a loaded word.
// Purely combinational so the store path can reuse it for lane selection.
module load_align
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        addr_i,
    input  logic [2:0]        load_type_i,
    output logic [DATA_W-1:0] data_o,
    output logic              misaligned_o
);

    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;

    // Pick the addressed byte and halfword; lane 0 is the most significant byte
    always_comb begin
        byte_sel = word_i[31:24];
        unique case (addr_i)
            2'd0: byte_sel = word_i[31:24];
            2'd1: byte_sel = word_i[23:16];
            2'd2: byte_sel = word_i[15:8];
            2'd3: byte_sel = word_i[7:0];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_i[1] ? word_i[15:0] : word_i[31:16];
    end

    // Extend the selected lane; unknown encodings behave as LW
    always_comb begin
        data_o       = word_i;
        misaligned_o = (addr_i != 2'd0);
        case (load_type_i)
            LT_LH: begin
                data_o       = {{(DATA_W - HALF_W){half_sel[HALF_W-1]}}, half_sel};
                misaligned_o = addr_i[0];
            end
            LT_LHU: begin
                data_o       = {{(DATA_W - HALF_W){1'b0}}, half_sel};
                misaligned_o = addr_i[0];
            end
            LT_LB: begin
                data_o       = {{(DATA_W - BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
                misaligned_o = 1'b0;
            end
            LT_LBU: begin
                data_o       = {{(DATA_W - BYTE_W){1'b0}}, byte_sel};
                misaligned_o = 1'b0;
            end
            default: begin
                data_o       = word_i;
                misaligned_o = (addr_i != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures load/ALU results, extracts sub-word loads,
// flags misaligned loads and drives the writeback and forwarding buses.
module mem_wb_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [1:0]            WB_control,
    input  logic [2:0]            load_type,
    input  logic [DATA_W-1:0]     data_from_mem,
    input  logic [DATA_W-1:0]     data_from_ALU,
    input  logic [REG_ADDR_W-1:0] reg_write,
    input  logic                  exc_clear,
    output logic [1:0]            WB_control_out,
    output logic [DATA_W-1:0]     wb_data,
    output logic [REG_ADDR_W-1:0] reg_write_out,
    output logic                  valid_out,
    output logic                  fwd_en,
    output logic                  misalign,
    output logic [CNT_W-1:0]      retired
);

    import mips_pkg::*;

    logic                  memtoreg_in;
    logic                  regwrite_in;
    logic [DATA_W-1:0]     load_data;
    logic                  lane_misaligned;
    logic                  load_fault;

    logic [1:0]            wb_ctrl_q, wb_ctrl_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  valid_q, valid_d;
    logic                  misalign_q, misalign_d;
    logic [CNT_W-1:0]      retired_q, retired_d;

    assign memtoreg_in = WB_control[WB_MEMTOREG];
    assign regwrite_in = WB_control[WB_REGWRITE];

    load_align u_load_align (
        .word_i       (data_from_mem),
        .addr_i       (data_from_ALU[1:0]),
        .load_type_i  (load_type),
        .data_o       (load_data),
        .misaligned_o (lane_misaligned)
    );

    // Only a real, valid load can fault; ALU results and stores never do
    assign load_fault = valid_in & memtoreg_in & lane_misaligned;

    // Next-state selection: flush > stall > capture
    always_comb begin
        wb_ctrl_d  = wb_ctrl_q;
        wb_data_d  = wb_data_q;
        rd_d       = rd_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        retired_d  = retired_q;

        if (exc_clear) begin
            misalign_d = 1'b0;
        end

        if (flush) begin
            wb_ctrl_d = 2'b00;
            wb_data_d = '0;
            rd_d      = '0;
            valid_d   = 1'b0;
        end else if (!stall) begin
            valid_d = valid_in;
            rd_d    = reg_write;
            // Select on MemtoReg alone so an undriven memory bus cannot leak into ALU results
            wb_data_d = memtoreg_in ? load_data : data_from_ALU;
            if (valid_in) begin
                wb_ctrl_d = {regwrite_in & ~load_fault, memtoreg_in};
                retired_d = retired_q + CNT_W'(1);
            end else begin
                wb_ctrl_d = 2'b00;
            end
            // A new fault wins over a simultaneous clear
            if (load_fault) begin
                misalign_d = 1'b1;
            end
        end
    end

    // Pipeline state with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_ctrl_q  <= 2'b00;
            wb_data_q  <= '0;
            rd_q       <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            wb_ctrl_q  <= wb_ctrl_d;
            wb_data_q  <= wb_data_d;
            rd_q       <= rd_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            retired_q  <= retired_d;
        end
    end

    assign WB_control_out = wb_ctrl_q;
    assign wb_data        = wb_data_q;
    assign reg_write_out  = rd_q;
    assign valid_out      = valid_q;
    assign misalign       = misalign_q;
    assign retired        = retired_q;
    // Writes to $0 are never forwarded
    assign fwd_en = wb_ctrl_q[WB_REGWRITE] & valid_q & (rd_q != '0);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a reference model pushes the expected
// output state for every edge, and each test pops and compares after the edge.
module tb_mem_wb_stage;

    typedef logic [73:0] obs_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic [1:0]  WB_control = 2'b00;
    logic [2:0]  load_type = 3'd0;
    logic [31:0] data_from_mem = '0;
    logic [31:0] data_from_ALU = '0;
    logic [4:0]  reg_write = '0;
    logic        exc_clear = 1'b0;

    logic [1:0]  WB_control_out;
    logic [31:0] wb_data;
    logic [4:0]  reg_write_out;
    logic        valid_out;
    logic        fwd_en;
    logic        misalign;
    logic [31:0] retired;

    logic [1:0]  wbc4;
    logic [31:0] wb_data4;
    logic [4:0]  rd4;
    logic        valid4, fwd4, mis4;
    logic [3:0]  retired4;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [1:0]  m_wbc;
    logic [31:0] m_data;
    logic [4:0]  m_reg;
    logic        m_valid, m_mis;
    logic [31:0] m_ret;
    obs_t        sb[$];
    obs_t        got, exp;

    mem_wb_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .WB_control(WB_control), .load_type(load_type), .data_from_mem(data_from_mem),
        .data_from_ALU(data_from_ALU), .reg_write(reg_write), .exc_clear(exc_clear),
        .WB_control_out(WB_control_out), .wb_data(wb_data), .reg_write_out(reg_write_out),
        .valid_out(valid_out), .fwd_en(fwd_en), .misalign(misalign), .retired(retired)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .WB_control(WB_control), .load_type(load_type), .data_from_mem(data_from_mem),
        .data_from_ALU(data_from_ALU), .reg_write(reg_write), .exc_clear(exc_clear),
        .WB_control_out(wbc4), .wb_data(wb_data4), .reg_write_out(rd4),
        .valid_out(valid4), .fwd_en(fwd4), .misalign(mis4), .retired(retired4)
    );

    always #5 clock = ~clock;

    function automatic obs_t observe();
        return {WB_control_out, wb_data, reg_write_out, valid_out, fwd_en, misalign, retired};
    endfunction

    function automatic obs_t model_obs();
        return {m_wbc, m_data, m_reg, m_valid, m_wbc[1] & m_valid & (m_reg != 5'd0), m_mis, m_ret};
    endfunction

    function automatic logic [31:0] model_ext(logic [2:0] lt, logic [31:0] mem, logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(mem >> (8 * (3 - int'(a))));
        h = 16'(mem >> (a[1] ? 0 : 16));
        case (lt)
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return {16'h0000, h};
            3'd3:    return {{24{b[7]}}, b};
            3'd4:    return {24'h000000, b};
            default: return mem;
        endcase
    endfunction

    // Drive one cycle of stimulus, advance the model, push its prediction, clock
    task automatic step(input logic st, input logic fl, input logic vin, input logic [1:0] wbc,
                        input logic [2:0] lt, input logic [31:0] mem, input logic [31:0] alu,
                        input logic [4:0] rd, input logic excl);
        logic fault;
        logic lw_like;
        stall = st; flush = fl; valid_in = vin; WB_control = wbc; load_type = lt;
        data_from_mem = mem; data_from_ALU = alu; reg_write = rd; exc_clear = excl;
        lw_like = !(lt inside {3'd1, 3'd2, 3'd3, 3'd4});
        fault = vin & wbc[0] & ((lw_like && alu[1:0] != 2'd0) ||
                                ((lt == 3'd1 || lt == 3'd2) && alu[0]));
        if (excl) m_mis = 1'b0;
        if (fl) begin
            m_valid = 1'b0; m_wbc = 2'b00; m_data = '0; m_reg = '0;
        end else if (!st) begin
            m_valid = vin;
            m_wbc   = vin ? {wbc[1] & ~fault, wbc[0]} : 2'b00;
            m_data  = wbc[0] ? model_ext(lt, mem, alu[1:0]) : alu;
            m_reg   = rd;
            if (fault) m_mis = 1'b1;
            if (vin) m_ret = m_ret + 32'd1;
        end
        sb.push_back(model_obs());
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        m_wbc = '0; m_data = '0; m_reg = '0; m_valid = 1'b0; m_mis = 1'b0; m_ret = '0;
        sb.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        got = observe();
        n_checks++;
        if (got !== obs_t'(0)) begin
            n_errors++; $display("FAIL reset_state: got %h expected 0", got);
        end
        n_checks++;
        if (retired4 !== 4'd0) begin
            n_errors++; $display("FAIL reset_retired4: got %0d expected 0", retired4);
        end
    endtask

    task automatic test_loads();
        logic [31:0] want [7];
        logic [2:0]  lts  [7];
        logic [31:0] mems [7];
        logic [1:0]  adrs [7];
        lts  = '{3'd3, 3'd4, 3'd1, 3'd0, 3'd2, 3'd3, 3'd4};
        mems = '{32'h12F45678, 32'h12F45678, 32'h12348001, 32'hCAFEF00D,
                 32'h12348001, 32'h000000A5, 32'h9A000000};
        adrs = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd2, 2'd3, 2'd0};
        want = '{32'hFFFFFFF4, 32'h000000F4, 32'hFFFF8001, 32'hCAFEF00D,
                 32'h00008001, 32'hFFFFFFA5, 32'h0000009A};
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, 2'b11, lts[i], mems[i], {28'h1000040, 2'b00, adrs[i]}, 5'd5, 0);
            got = observe(); exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++; $display("FAIL load_%0d: got %h expected %h", i, got, exp);
            end
            n_checks++;
            if (wb_data !== want[i] || reg_write_out !== 5'd5 || fwd_en !== 1'b1) begin
                n_errors++;
                $display("FAIL load_value_%0d: got data=%h rd=%0d fwd=%b expected %h 5 1",
                         i, wb_data, reg_write_out, fwd_en, want[i]);
            end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] r0;
        r0 = m_ret;
        step(0, 0, 1, 2'b11, 3'd0, 32'h11223344, 32'h00000102, 5'd7, 0);
        got = observe(); exp = sb.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL misalign_lw: got %h expected %h", got, exp);
        end
        n_checks++;
        if (WB_control_out[1] !== 1'b0 || misalign !== 1'b1 || valid_out !== 1'b1 ||
            retired !== r0 + 32'd1) begin
            n_errors++;
            $display("FAIL misalign_flags: got rw=%b mis=%b v=%b ret=%0d expected 0 1 1 %0d",
                     WB_control_out[1], misalign, valid_out, retired, r0 + 32'd1);
        end
        // clear with no new fault, clear racing a new fault, LH odd, LB odd (legal), clear
        step(0, 0, 0, 2'b00, 3'd0, 32'h0, 32'h0, 5'd0, 1);
        step(0, 0, 1, 2'b11, 3'd2, 32'h0, 32'h00000003, 5'd3, 1);
        step(0, 0, 0, 2'b00, 3'd0, 32'h0, 32'h0, 5'd0, 1);
        step(0, 0, 1, 2'b11, 3'd1, 32'hAABBCCDD, 32'h00000001, 5'd4, 0);
        step(0, 0, 1, 2'b11, 3'd3, 32'hAABBCCDD, 32'h00000001, 5'd4, 1);
        while (sb.size() > 0) begin
            got = observe(); exp = sb.pop_front();
        end
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL misalign_seq: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_misalign_each();
        // Per-edge comparison of the clear/fault interplay
        step(0, 0, 1, 2'b11, 3'd7, 32'h01020304, 32'h00000001, 5'd9, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) step(0, 0, 0, 2'b00, 3'd0, 32'h0, 32'h0, 5'd0, 1);
            if (i == 1) step(0, 0, 1, 2'b10, 3'd0, 32'h0, 32'h00000003, 5'd2, 1);
            if (i == 2) step(0, 0, 1, 2'b11, 3'd1, 32'h0, 32'h00000003, 5'd2, 1);
        end
        while (sb.size() > 1) begin
            void'(sb.pop_front());
        end
        got = observe(); exp = sb.pop_front();
        n_checks++;
        if (got !== exp || misalign !== 1'b1) begin
            n_errors++; $display("FAIL clear_vs_fault: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_stall_flush();
        step(0, 0, 1, 2'b10, 3'd0, 32'h0, 32'h00001234, 5'd12, 0);
        got = observe(); exp = sb.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL pre_stall: got %h expected %h", got, exp);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 2'b11, 3'(i), $urandom, $urandom, 5'(i + 20), 0);
            got = observe(); exp = sb.pop_front();
            n_checks++;
            if (got !== exp || wb_data !== 32'h00001234 || reg_write_out !== 5'd12) begin
                n_errors++; $display("FAIL stall_%0d: got %h expected %h", i, got, exp);
            end
        end
        step(1, 1, 1, 2'b11, 3'd0, 32'h55555555, 32'h00000008, 5'd6, 0);
        got = observe(); exp = sb.pop_front();
        n_checks++;
        if (got !== exp || valid_out !== 1'b0 || WB_control_out !== 2'b00) begin
            n_errors++; $display("FAIL stall_flush: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_alu_fwd();
        step(0, 0, 1, 2'b10, 3'd0, 32'hxxxxxxxx, 32'hDEADBEEF, 5'd0, 0);
        got = observe(); exp = sb.pop_front();
        n_checks++;
        if (got !== exp || wb_data !== 32'hDEADBEEF || fwd_en !== 1'b0) begin
            n_errors++; $display("FAIL alu_r0: got %h expected %h", got, exp);
        end
        step(0, 0, 1, 2'b10, 3'd0, 32'hxxxxxxxx, 32'h0BADF00D, 5'd31, 0);
        got = observe(); exp = sb.pop_front();
        n_checks++;
        if (got !== exp || fwd_en !== 1'b1) begin
            n_errors++; $display("FAIL alu_fwd: got %h expected %h", got, exp);
        end
        // store: valid, no write
        step(0, 0, 1, 2'b00, 3'd0, 32'hxxxxxxxx, 32'h00000100, 5'd8, 0);
        got = observe(); exp = sb.pop_front();
        n_checks++;
        if (got !== exp || valid_out !== 1'b1 || fwd_en !== 1'b0) begin
            n_errors++; $display("FAIL store: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 2'b10, 3'd0, 32'h0, 32'(i * 4), 5'(i + 1), 0);
        end
        step(0, 0, 1, 2'b11, 3'd0, 32'h0, 32'h00000002, 5'd1, 0);
        while (sb.size() > 1) void'(sb.pop_front());
        got = observe(); exp = sb.pop_front();
        n_checks++;
        if (got !== exp || retired !== 32'd7 || misalign !== 1'b1) begin
            n_errors++; $display("FAIL midrun_setup: got %h expected %h", got, exp);
        end
        #2;
        reset = 1'b0;
        #1;
        got = observe();
        n_checks++;
        if (got !== obs_t'(0) || retired4 !== 4'd0) begin
            n_errors++; $display("FAIL async_reset: got %h expected 0", got);
        end
        apply_reset();
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 1, 2'b00, 3'd0, 32'h0, 32'h0, 5'd0, 0);
        end
        sb.delete();
        n_checks++;
        if (retired4 !== 4'd15 || retired !== 32'd15) begin
            n_errors++; $display("FAIL wrap_pre: got %0d/%0d expected 15/15", retired4, retired);
        end
        step(0, 0, 1, 2'b00, 3'd0, 32'h0, 32'h0, 5'd0, 0);
        got = observe(); exp = sb.pop_front();
        n_checks++;
        if (retired4 !== m_ret[3:0] || got !== exp) begin
            n_errors++; $display("FAIL wrap: got %0d expected %0d", retired4, m_ret[3:0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, 1'($urandom),
                 2'($urandom), 3'($urandom_range(0, 6)), $urandom, $urandom, 5'($urandom),
                 $urandom_range(0, 3) == 0);
            got = observe(); exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++; $display("FAIL random_%0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_misalign();
        test_misalign_each();
        test_stall_flush();
        test_alu_fwd();
        test_reset_midrun();
        test_counter_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
